// File: rtl/race_timer.sv
// Multi-player race timing engine: start countdown, per-player lap/best times,
// finish detection and first-finisher arbitration, all on a shared tick prescaler.
module race_timer #(
  parameter int PLAYERS         = 2,
  parameter int LAPS            = 3,
  parameter int TIME_W          = 16,
  parameter int TICK_DIV        = 650000,
  parameter int COUNTDOWN_TICKS = 300,
  localparam int LAP_W          = $clog2(LAPS + 1),
  localparam int WIN_W          = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
  input  logic                      pclk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [PLAYERS-1:0]        lap_finished,
  output logic                      countdown_active,
  output logic [TIME_W-1:0]         countdown_left,
  output logic                      racing,
  output logic [PLAYERS*TIME_W-1:0] current_lap_time,
  output logic [PLAYERS*TIME_W-1:0] last_lap_time,
  output logic [PLAYERS*TIME_W-1:0] best_lap_time,
  output logic [PLAYERS*LAP_W-1:0]  lap_count,
  output logic [PLAYERS-1:0]        player_done,
  output logic [TIME_W-1:0]         race_time,
  output logic                      race_over,
  output logic [WIN_W-1:0]          winner,
  output logic                      winner_valid
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, COUNTDOWN, RACING, FINISHED} state_t;

  state_t                           state_q, state_d;
  logic                             start_q;
  logic [PW-1:0]                    presc_q, presc_d;
  logic [TIME_W-1:0]                cd_left_q, cd_left_d;
  logic                             cd_act_q, cd_act_d;
  logic                             racing_q, racing_d;
  logic [PLAYERS-1:0][TIME_W-1:0]   cur_q, cur_d;
  logic [PLAYERS-1:0][TIME_W-1:0]   last_q, last_d;
  logic [PLAYERS-1:0][TIME_W-1:0]   best_q, best_d;
  logic [PLAYERS-1:0][LAP_W-1:0]    lap_q, lap_d;
  logic [PLAYERS-1:0]               done_q, done_d;
  logic [PLAYERS-1:0]               newly_done;
  logic [TIME_W-1:0]                rtime_q, rtime_d;
  logic                             over_q, over_d;
  logic [WIN_W-1:0]                 winner_q, winner_d;
  logic                             wv_q, wv_d;
  logic                             start_rise;
  logic                             tick;

  function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [TIME_W-1:0] min_time(input logic [TIME_W-1:0] a,
                                                 input logic [TIME_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  assign start_rise = start & ~start_q;
  assign tick = ((state_q == COUNTDOWN) || (state_q == RACING)) &&
                (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    cd_left_d  = cd_left_q;
    cur_d      = cur_q;
    last_d     = last_q;
    best_d     = best_q;
    lap_d      = lap_q;
    done_d     = done_q;
    rtime_d    = rtime_q;
    over_d     = over_q;
    winner_d   = winner_q;
    wv_d       = wv_q;
    newly_done = '0;

    if ((state_q == COUNTDOWN) || (state_q == RACING))
      presc_d = tick ? '0 : presc_q + 1'b1;

    // Dropping start aborts from any active state with every value frozen.
    if ((state_q != IDLE) && !start) begin
      state_d = IDLE;
      presc_d = presc_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_rise) begin
            cur_d     = '0;
            last_d    = '0;
            best_d    = '1;
            lap_d     = '0;
            done_d    = '0;
            rtime_d   = '0;
            over_d    = 1'b0;
            winner_d  = '0;
            wv_d      = 1'b0;
            presc_d   = '0;
            cd_left_d = TIME_W'(COUNTDOWN_TICKS);
            state_d   = (COUNTDOWN_TICKS == 0) ? RACING : COUNTDOWN;
          end
        end
        COUNTDOWN: begin
          if (tick) begin
            cd_left_d = cd_left_q - 1'b1;
            if (cd_left_q <= TIME_W'(1)) begin
              cd_left_d = '0;
              state_d   = RACING;
              presc_d   = '0;
            end
          end
        end
        RACING: begin
          for (int p = 0; p < PLAYERS; p++) begin
            if (!done_q[p]) begin
              if (lap_finished[p]) begin
                last_d[p] = cur_q[p];
                best_d[p] = min_time(best_q[p], cur_q[p]);
                cur_d[p]  = '0;
                lap_d[p]  = lap_q[p] + 1'b1;
                if (lap_q[p] + 1'b1 == LAP_W'(LAPS))
                  done_d[p] = 1'b1;
              end else if (tick) begin
                cur_d[p] = sat_inc(cur_q[p]);
              end
            end
          end
          newly_done = done_d & ~done_q;
          if (!wv_q && (|newly_done)) begin
            wv_d = 1'b1;
            for (int p = PLAYERS - 1; p >= 0; p--)
              if (newly_done[p]) winner_d = WIN_W'(p);
          end
          if (tick && !(&done_q))
            rtime_d = sat_inc(rtime_q);
          over_d = &done_q;
          if (over_q)
            state_d = FINISHED;
        end
        FINISHED: ;
        default: state_d = IDLE;
      endcase
    end

    cd_act_d = (state_d == COUNTDOWN);
    racing_d = (state_d == RACING);
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      presc_q   <= '0;
      cd_left_q <= '0;
      cd_act_q  <= 1'b0;
      racing_q  <= 1'b0;
      cur_q     <= '0;
      last_q    <= '0;
      best_q    <= '1;
      lap_q     <= '0;
      done_q    <= '0;
      rtime_q   <= '0;
      over_q    <= 1'b0;
      winner_q  <= '0;
      wv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      presc_q   <= presc_d;
      cd_left_q <= cd_left_d;
      cd_act_q  <= cd_act_d;
      racing_q  <= racing_d;
      cur_q     <= cur_d;
      last_q    <= last_d;
      best_q    <= best_d;
      lap_q     <= lap_d;
      done_q    <= done_d;
      rtime_q   <= rtime_d;
      over_q    <= over_d;
      winner_q  <= winner_d;
      wv_q      <= wv_d;
    end
  end

  assign countdown_active = cd_act_q;
  assign countdown_left   = cd_left_q;
  assign racing           = racing_q;
  assign current_lap_time = cur_q;
  assign last_lap_time    = last_q;
  assign best_lap_time    = best_q;
  assign lap_count        = lap_q;
  assign player_done      = done_q;
  assign race_time        = rtime_q;
  assign race_over        = over_q;
  assign winner           = winner_q;
  assign winner_valid     = wv_q;

endmodule

// File: tb/tb_race_timer.sv
// Directed bench for race_timer: two instances (16-bit and 4-bit time) checked
// through an expectation queue filled as stimulus is applied.
module tb_race_timer;

  logic       pclk = 1'b0;
  logic       rst;
  logic       start, start_b;
  logic [1:0] lap, lap_b;

  logic        a_cda, a_rac, a_over, a_win, a_wv;
  logic [15:0] a_cdl, a_rt;
  logic [31:0] a_cur, a_last, a_best;
  logic [3:0]  a_lap;
  logic [1:0]  a_done;

  logic        b_cda, b_rac, b_over, b_win, b_wv;
  logic [3:0]  b_cdl, b_rt;
  logic [7:0]  b_cur, b_last, b_best;
  logic [3:0]  b_lap;
  logic [1:0]  b_done;

  always #5 pclk = ~pclk;

  race_timer #(.PLAYERS(2), .LAPS(2), .TIME_W(16), .TICK_DIV(4), .COUNTDOWN_TICKS(3)) dut_a (
    .pclk(pclk), .rst(rst), .start(start), .lap_finished(lap),
    .countdown_active(a_cda), .countdown_left(a_cdl), .racing(a_rac),
    .current_lap_time(a_cur), .last_lap_time(a_last), .best_lap_time(a_best),
    .lap_count(a_lap), .player_done(a_done), .race_time(a_rt), .race_over(a_over),
    .winner(a_win), .winner_valid(a_wv));

  race_timer #(.PLAYERS(2), .LAPS(2), .TIME_W(4), .TICK_DIV(4), .COUNTDOWN_TICKS(3)) dut_b (
    .pclk(pclk), .rst(rst), .start(start_b), .lap_finished(lap_b),
    .countdown_active(b_cda), .countdown_left(b_cdl), .racing(b_rac),
    .current_lap_time(b_cur), .last_lap_time(b_last), .best_lap_time(b_best),
    .lap_count(b_lap), .player_done(b_done), .race_time(b_rt), .race_over(b_over),
    .winner(b_win), .winner_valid(b_wv));

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (sbq.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty: observed %0h with no expectation queued", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; start_b = 1'b0; lap = 2'b00; lap_b = 2'b00;

    // reset state
    push("rst_cda", 0); push("rst_cdl", 0); push("rst_cur", 0);
    push("rst_best", 32'hFFFF_FFFF); push("rst_lap", 0); push("rst_wv", 0);
    cyc(2);
    chk(a_cda); chk(a_cdl); chk(a_cur); chk(a_best); chk(a_lap); chk(a_wv);

    // race 1: countdown then player0 finishes alone
    rst = 1'b1; start = 1'b1;
    push("cd_act", 1); push("cd_left3", 3); push("cd_racing", 0);
    cyc(1);
    chk(a_cda); chk(a_cdl); chk(a_rac);
    lap = 2'b11;
    cyc(1);
    lap = 2'b00;
    push("cd_left3b", 3);
    cyc(2); chk(a_cdl);
    push("cd_left2", 2);
    cyc(1); chk(a_cdl);
    push("cd_left1", 1);
    cyc(4); chk(a_cdl);
    push("cd_left1_r", 0);
    cyc(3); chk(a_rac);
    push("cd_left0", 0); push("race_on", 1); push("cd_off", 0); push("cd_lap_ign", 0);
    cyc(1);
    chk(a_cdl); chk(a_rac); chk(a_cda); chk(a_lap);

    push("cur_10", 32'h000A_000A);
    cyc(41); chk(a_cur);
    lap = 2'b01;
    push("l1_last", 32'h0000_000A); push("l1_best", 32'hFFFF_000A);
    push("l1_lap", 4'b0001); push("l1_cur", 32'h000A_0000); push("l1_done", 0);
    cyc(1);
    lap = 2'b00;
    chk(a_last); chk(a_best); chk(a_lap); chk(a_cur); chk(a_done);

    push("cur_7", 32'h0011_0007);
    cyc(26); chk(a_cur);
    lap = 2'b01;
    push("l2_last", 32'h0000_0007); push("l2_best", 32'hFFFF_0007); push("l2_lap", 4'b0010);
    push("l2_done", 2'b01); push("l2_win", 0); push("l2_wv", 1); push("l2_rt", 17);
    cyc(1);
    lap = 2'b00;
    chk(a_last); chk(a_best); chk(a_lap); chk(a_done); chk(a_win); chk(a_wv); chk(a_rt);
    push("p1_counts", 32'h0012_0000); push("rt_18", 18);
    cyc(4); chk(a_cur); chk(a_rt);

    // drop start: hold everything
    start = 1'b0;
    push("drop_racing", 0); push("drop_cur", 32'h0012_0000);
    cyc(1); chk(a_rac); chk(a_cur);
    push("hold_cur", 32'h0012_0000); push("hold_rt", 18); push("hold_lap", 4'b0010);
    cyc(8); chk(a_cur); chk(a_rt); chk(a_lap);

    // restart clears everything
    start = 1'b1;
    push("rs_cda", 1); push("rs_cdl", 3); push("rs_cur", 0); push("rs_last", 0);
    push("rs_best", 32'hFFFF_FFFF); push("rs_lap", 0); push("rs_done", 0);
    push("rs_wv", 0); push("rs_rt", 0);
    cyc(1);
    chk(a_cda); chk(a_cdl); chk(a_cur); chk(a_last); chk(a_best); chk(a_lap);
    chk(a_done); chk(a_wv); chk(a_rt);

    // race 2: both players finish in the same cycle
    push("r2_racing", 1);
    cyc(12); chk(a_rac);
    cyc(5);
    lap = 2'b11;
    push("r2_lap1", 4'b0101); push("r2_last1", 32'h0001_0001); push("r2_done0", 0);
    cyc(1);
    lap = 2'b00;
    chk(a_lap); chk(a_last); chk(a_done);
    cyc(8);
    lap = 2'b11;
    push("r2_done", 2'b11); push("r2_win", 0); push("r2_wv", 1); push("r2_over0", 0);
    push("r2_last2", 32'h0002_0002); push("r2_best", 32'h0001_0001); push("r2_rt", 3);
    cyc(1);
    lap = 2'b00;
    chk(a_done); chk(a_win); chk(a_wv); chk(a_over); chk(a_last); chk(a_best); chk(a_rt);
    push("r2_over1", 1);
    cyc(1); chk(a_over);
    push("r2_fin", 0);
    cyc(1); chk(a_rac);
    push("r2_rt_frz", 3); push("r2_cur_frz", 0);
    cyc(8); chk(a_rt); chk(a_cur);

    // race 3: player1 first, late pulses ignored, then reset mid-race
    start = 1'b0;
    cyc(1);
    start = 1'b1;
    cyc(1);
    push("r3_racing", 1);
    cyc(12); chk(a_rac);
    lap = 2'b10; cyc(1); lap = 2'b00; cyc(1);
    lap = 2'b10;
    push("r3_done", 2'b10); push("r3_win", 1); push("r3_wv", 1); push("r3_lap", 4'b1000);
    cyc(1);
    lap = 2'b00;
    chk(a_done); chk(a_win); chk(a_wv); chk(a_lap);
    lap = 2'b11;
    push("r3_ign", 4'b1001); push("r3_win_keep", 1); push("r3_tick_drop", 0);
    cyc(1);
    lap = 2'b00;
    chk(a_lap); chk(a_win); chk(a_cur);

    rst = 1'b0; start = 1'b0;
    push("ar_racing", 0); push("ar_best", 32'hFFFF_FFFF); push("ar_lap", 0);
    push("ar_wv", 0); push("ar_win", 0); push("ar_done", 0); push("ar_cur", 0);
    #1;
    chk(a_rac); chk(a_best); chk(a_lap); chk(a_wv); chk(a_win); chk(a_done); chk(a_cur);
    cyc(1);
    rst = 1'b1;
    push("ar_idle_cda", 0); push("ar_idle_rac", 0);
    cyc(2); chk(a_cda); chk(a_rac);

    // 4-bit instance: saturation
    start_b = 1'b1;
    cyc(1);
    push("b_racing", 1);
    cyc(12); chk(b_rac);
    push("b_cur_sat", 8'hFF); push("b_rt_sat", 4'hF);
    cyc(82); chk(b_cur); chk(b_rt);
    lap_b = 2'b01;
    push("b_last", 8'h0F); push("b_best", 8'hFF); push("b_lap", 4'b0001); push("b_cur", 8'hF0);
    cyc(1);
    lap_b = 2'b00;
    chk(b_last); chk(b_best); chk(b_lap); chk(b_cur);

    if (sbq.size() != 0) begin
      n_vec++;
      n_err++;
      $error("FAIL sb_leftover: observed %0d pending expected 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
